// File: rtl/riscv_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// riscv_ctrl_pkg
// Shared definitions for the RV64 multicycle control unit: the major opcodes
// the controller understands, the ALUOp encodings consumed by the execute
// stage's ALU-control decoder, and the state / instruction-class enums.
// No ports (package).
// ----------------------------------------------------------------------------
package riscv_ctrl_pkg;

    // Major opcodes (instruction[6:0]) recognised by the controller
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_SD    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    // ALUOp encodings understood by the execute-stage ALU-control block
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } ctrlState_e;

    // Instruction class captured in DECODE
    typedef enum logic [1:0] {
        CLS_LD    = 2'd0,
        CLS_SD    = 2'd1,
        CLS_RTYPE = 2'd2,
        CLS_BEQ   = 2'd3
    } instrClass_e;

endpackage

// File: rtl/opcode_class_dec.sv
// ----------------------------------------------------------------------------
// opcode_class_dec
// Purely combinational classifier: maps a 7-bit major opcode onto one of the
// supported instruction classes and flags whether the opcode is supported.
// Kept separate so a pipelined control unit can share the same decode.
//   i_opcode  in   7  instruction[6:0]
//   o_class   out  2  instruction class (valid only when o_legal = 1)
//   o_legal   out  1  opcode is one of ld / sd / R-type / beq
// ----------------------------------------------------------------------------
module opcode_class_dec
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0]  i_opcode,
    output instrClass_e o_class,
    output logic        o_legal
);

    // Straight table lookup; anything outside the four supported opcodes is
    // reported illegal and the class output is a don't-care defaulted to R-type.
    always_comb begin
        o_class = CLS_RTYPE;
        o_legal = 1'b1;
        case (i_opcode)
            OP_LD:    o_class = CLS_LD;
            OP_SD:    o_class = CLS_SD;
            OP_RTYPE: o_class = CLS_RTYPE;
            OP_BEQ:   o_class = CLS_BEQ;
            default:  o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_exec_ctrl.sv
// ----------------------------------------------------------------------------
// multicycle_exec_ctrl
// Multicycle sequencer for the RV64 datapath. Steps each instruction through
// FETCH / DECODE / EXEC / MEM / WB, drives the datapath enables and the
// execute-stage controls, handshakes with a variable-latency memory, counts
// retired instructions and halts on an illegal opcode or a memory timeout.
//   i_clk        in   1      system clock, rising edge
//   i_reset      in   1      synchronous active-high reset
//   i_start      in   1      run while high (sampled in IDLE and at retire)
//   i_opcode     in   7      instruction[6:0] from IR, valid from DECODE on
//   i_mem_ready  in   1      memory completes the current request
//   o_mem_req    out  1      memory request pending
//   o_MemRead    out  1      read strobe (fetch or ld)
//   o_MemWrite   out  1      write strobe (sd)
//   o_IRWrite    out  1      latch fetched word into IR
//   o_RegWrite   out  1      register-file write enable
//   o_MemtoReg   out  1      1 = writeback from memory, 0 = from ALU
//   o_PCWrite    out  1      PC <= execute-stage next-PC
//   o_ALUOp      out  2      00 add, 01 sub, 10 R-type
//   o_ALUSrc     out  1      1 = read_data2, 0 = immediate
//   o_Branch     out  1      branch qualifier (ANDed with zero downstream)
//   o_busy       out  1      not IDLE and not HALT
//   o_halted     out  1      in HALT
//   o_illegal    out  1      sticky: halted on unsupported opcode
//   o_bus_err    out  1      sticky: halted on memory timeout
//   o_instret    out  CNT_W  retired-instruction count (wraps)
// ----------------------------------------------------------------------------
module multicycle_exec_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 64
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [6:0]       i_opcode,
    input  logic             i_mem_ready,
    output logic             o_mem_req,
    output logic             o_MemRead,
    output logic             o_MemWrite,
    output logic             o_IRWrite,
    output logic             o_RegWrite,
    output logic             o_MemtoReg,
    output logic             o_PCWrite,
    output logic [1:0]       o_ALUOp,
    output logic             o_ALUSrc,
    output logic             o_Branch,
    output logic             o_busy,
    output logic             o_halted,
    output logic             o_illegal,
    output logic             o_bus_err,
    output logic [CNT_W-1:0] o_instret
);

    // The wait counter only has to reach MEM_TIMEOUT-1; the timeout fires on
    // the cycle that would take it to MEM_TIMEOUT.
    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    ctrlState_e         r_state;
    instrClass_e        r_class;
    logic [WAIT_W-1:0]  r_wait;
    logic [CNT_W-1:0]   r_instret;
    logic               r_illegal;
    logic               r_busErr;

    instrClass_e        w_decClass;
    logic               w_decLegal;
    logic               w_retire;
    logic               w_waitExpired;

    opcode_class_dec u_dec (
        .i_opcode (i_opcode),
        .o_class  (w_decClass),
        .o_legal  (w_decLegal)
    );

    // An instruction retires in exactly one cycle: beq in EXEC, sd in MEM when
    // memory accepts the write, ld and R-type in WB. The timeout fires when a
    // request is still unanswered and the counter is on its last allowed value;
    // a mem_ready in that same cycle wins.
    always_comb begin
        w_retire = 1'b0;
        case (r_state)
            ST_EXEC: w_retire = (r_class == CLS_BEQ);
            ST_MEM:  w_retire = (r_class == CLS_SD) && i_mem_ready;
            ST_WB:   w_retire = 1'b1;
            default: w_retire = 1'b0;
        endcase
        w_waitExpired = !i_mem_ready && (r_wait == WAIT_LAST);
    end

    // Main sequencer: state, captured class, memory wait counter, sticky halt
    // causes and the retire counter. Retirement is handled after the case so
    // every retiring state shares the same next-state rule (FETCH if start is
    // still high, otherwise IDLE) and the counter is always cleared on the way
    // back into FETCH.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_class   <= CLS_LD;
            r_wait    <= '0;
            r_instret <= '0;
            r_illegal <= 1'b0;
            r_busErr  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state <= ST_FETCH;
                        r_wait  <= '0;
                    end
                end
                ST_FETCH: begin
                    if (i_mem_ready) begin
                        r_state <= ST_DECODE;
                    end else if (w_waitExpired) begin
                        r_state  <= ST_HALT;
                        r_busErr <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                ST_DECODE: begin
                    if (w_decLegal) begin
                        r_class <= w_decClass;
                        r_state <= ST_EXEC;
                    end else begin
                        r_state   <= ST_HALT;
                        r_illegal <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    case (r_class)
                        CLS_LD, CLS_SD: begin
                            r_state <= ST_MEM;
                            r_wait  <= '0;
                        end
                        CLS_RTYPE: r_state <= ST_WB;
                        default:   r_state <= ST_EXEC;
                    endcase
                end
                ST_MEM: begin
                    if (i_mem_ready) begin
                        if (r_class == CLS_LD) begin
                            r_state <= ST_WB;
                        end
                    end else if (w_waitExpired) begin
                        r_state  <= ST_HALT;
                        r_busErr <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                ST_WB:   r_state <= ST_WB;
                ST_HALT: r_state <= ST_HALT;
                default: r_state <= ST_IDLE;
            endcase

            if (w_retire) begin
                r_instret <= r_instret + 1'b1;
                r_wait    <= '0;
                r_state   <= i_start ? ST_FETCH : ST_IDLE;
            end
        end
    end

    // Moore decode of the control strobes from the registered state and class.
    // The only mem_ready-qualified strobes are IRWrite in FETCH and the sd
    // PCWrite in MEM, which must coincide with the cycle memory completes.
    always_comb begin
        o_mem_req  = 1'b0;
        o_MemRead  = 1'b0;
        o_MemWrite = 1'b0;
        o_IRWrite  = 1'b0;
        o_RegWrite = 1'b0;
        o_MemtoReg = 1'b0;
        o_PCWrite  = 1'b0;
        o_ALUOp    = ALUOP_ADD;
        o_ALUSrc   = 1'b0;
        o_Branch   = 1'b0;
        case (r_state)
            ST_FETCH: begin
                o_mem_req = 1'b1;
                o_MemRead = 1'b1;
                o_IRWrite = i_mem_ready;
            end
            ST_EXEC: begin
                case (r_class)
                    CLS_RTYPE: begin
                        o_ALUOp  = ALUOP_RTYPE;
                        o_ALUSrc = 1'b1;
                    end
                    CLS_BEQ: begin
                        o_ALUOp   = ALUOP_SUB;
                        o_ALUSrc  = 1'b1;
                        o_Branch  = 1'b1;
                        o_PCWrite = 1'b1;
                    end
                    default: begin
                        o_ALUOp  = ALUOP_ADD;
                        o_ALUSrc = 1'b0;
                    end
                endcase
            end
            ST_MEM: begin
                o_mem_req  = 1'b1;
                o_MemRead  = (r_class == CLS_LD);
                o_MemWrite = (r_class == CLS_SD);
                o_PCWrite  = (r_class == CLS_SD) && i_mem_ready;
            end
            ST_WB: begin
                o_RegWrite = 1'b1;
                o_MemtoReg = (r_class == CLS_LD);
                o_PCWrite  = 1'b1;
            end
            default: begin
                o_mem_req = 1'b0;
            end
        endcase
    end

    assign o_busy    = (r_state != ST_IDLE) && (r_state != ST_HALT);
    assign o_halted  = (r_state == ST_HALT);
    assign o_illegal = r_illegal;
    assign o_bus_err = r_busErr;
    assign o_instret = r_instret;

endmodule

// File: doc/multicycle_exec_ctrl.md
Name: multicycle_exec_ctrl

Overview:
- Multicycle sequencer for the RV64 datapath: fetch, execute (ALU, ALU-control decode, branch-target mux), data memory and register-file writeback.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the execute stage's ALUOp, ALUSrc and Branch controls.
- Drives the PC/IR/regfile/memory enables and handshakes with a variable-latency memory.
- Counts retired instructions and halts on an illegal opcode or a memory timeout.

Parameters:
- MEM_TIMEOUT, 255: max cycles mem_req may wait for mem_ready before a bus error.
- CNT_W, 64: width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  level: run while high; sampled at retirement and in IDLE.
- opcode  input  7  instruction[6:0] from IR, valid from DECODE onward.
- mem_ready  input  1  memory completes the current request this cycle.
- mem_req  output  1  memory request pending.
- MemRead  output  1  read strobe (fetch or ld).
- MemWrite  output  1  write strobe (sd).
- IRWrite  output  1  latch fetched word into IR.
- RegWrite  output  1  regfile write enable.
- MemtoReg  output  1  1 = writeback from memory, 0 = from alu_result.
- PCWrite  output  1  PC <= execute-stage next-PC ("in") this cycle.
- ALUOp  output  2  00 add (ld/sd), 01 sub (beq), 10 R-type.
- ALUSrc  output  1  1 = read_data2, 0 = imm_out. Matches the execute-stage mux polarity: sel=1 picks a.
- Branch  output  1  branch qualifier, ANDed with zero in the execute stage.
- busy  output  1  state != IDLE and != HALT.
- halted  output  1  in HALT.
- illegal  output  1  sticky: halt cause = unsupported opcode.
- bus_err  output  1  sticky: halt cause = memory timeout.
- instret  output  CNT_W  retired-instruction count.

Behaviour:
- Reset:
  - State = IDLE; every output 0; instret = 0; sticky flags cleared; wait counter = 0.
  - Reset mid-operation aborts the instruction with no retire; mem_req is low the cycle after reset.
- Outputs: Moore, decoded from the registered state and an instruction class captured in DECODE (LD, SD, RTYPE, BEQ).
- States and transitions:
  - IDLE: all strobes 0. start=1 -> FETCH.
  - FETCH: mem_req=1, MemRead=1.
    - mem_ready=1 -> IRWrite=1 that same cycle, then -> DECODE.
    - Otherwise stay.
  - DECODE (1 cycle): latch class from opcode.
    - 0000011 LD, 0100011 SD, 0110011 RTYPE, 1100011 BEQ -> EXEC.
    - Any other opcode -> HALT with illegal=1.
  - EXEC (1 cycle):
    - LD/SD: ALUOp=00, ALUSrc=0 -> MEM.
    - RTYPE: ALUOp=10, ALUSrc=1 -> WB.
    - BEQ: ALUOp=01, ALUSrc=1, Branch=1, PCWrite=1; instruction retires here.
  - MEM: ALUOp=00, ALUSrc=0 held; mem_req=1; MemRead=1 for LD, MemWrite=1 for SD.
    - On mem_ready: LD -> WB; SD asserts PCWrite=1 and retires.
  - WB (1 cycle): RegWrite=1, MemtoReg = (class==LD), PCWrite=1; retires.
  - HALT: all strobes 0; only reset exits.
- Retire cycle:
  - instret += 1, wrapping modulo 2^CNT_W.
  - Next state = FETCH if start=1, else IDLE. start falling mid-instruction never aborts it.
- PCWrite with Branch=0 selects PC4.
- Latency with zero-wait memory: R-type 4 cycles, beq 3, sd 4, ld 5. Each memory wait cycle adds 1.
- Timeout:
  - The wait counter clears on entry to FETCH/MEM and increments each cycle mem_req=1 && mem_ready=0.
  - Reaching MEM_TIMEOUT -> HALT, bus_err=1, mem_req drops next cycle.
  - mem_ready on the same cycle the counter reaches MEM_TIMEOUT counts as success.
- mem_ready outside FETCH/MEM is ignored.
- At most one of MemRead/MemWrite is high; IRWrite only in FETCH.

Decomposition:
- Package riscv_ctrl_pkg:
  - Opcode constants (OP_LD, OP_SD, OP_RTYPE, OP_BEQ).
  - ALUOp encodings (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_RTYPE=10).
  - State enum and instruction-class enum.
- Sub-module opcode_class_dec: combinational opcode -> {class, legal}. It is reused by a future pipelined control unit.
- FSM, wait counter and instret live in multicycle_exec_ctrl.

Test Plan:
- R-type, zero-wait: reset, start=1, fetch returns opcode 0110011.
  - Cycle 2: IRWrite; cycle 3: ALUOp=10, ALUSrc=1; cycle 4: RegWrite=1, MemtoReg=0, PCWrite=1; instret=1.
- ld with mem_ready delayed 3 cycles in MEM:
  - mem_req/MemRead held 4 cycles; WB has MemtoReg=1, RegWrite=1; total 8 cycles; instret increments once.
- beq then sd back-to-back:
  - beq: EXEC shows Branch=1, ALUOp=01, PCWrite=1, no RegWrite.
  - sd: MEM shows MemWrite=1, MemRead=0, PCWrite on mem_ready; instret=2.
- Opcode 0010011:
  - DECODE -> HALT; illegal=1, halted=1, busy=0, no strobes.
  - start toggling has no effect; reset clears illegal.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH:
  - HALT after 4 wait cycles, bus_err=1, mem_req=0 next cycle.
  - Repeat with mem_ready arriving on the 4th cycle: no error.
- Edge cases:
  - start drops during ld MEM: ld completes WB, then IDLE, instret=1.
  - reset asserted in MEM: IDLE next cycle, mem_req=0, instret=0.
  - Counter wrap with CNT_W=4 after 16 retires -> 0.
